// File: rtl/mips31_pkg.sv
// Shared constants and types for the MIPS front end: reset PC, NOP encoding,
// PC increment and the {pc, instr} entry carried through the fetch queue.
package mips31_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read port: the fetch unit drives strobe and address,
// the memory returns data one cycle after each strobe.
interface pc_fetch_unit_if;

    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata
    );

endinterface

// File: rtl/pc_fetch_unit_fetch_queue.sv
// Two-entry {pc, instr} FIFO between the IMEM response and the IF/ID register,
// with same-cycle push/pop and a flush that empties it for redirects.
module fetch_queue
    import mips31_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        // NOTE: every signal gets a default before the branches so no path leaves one unassigned (no latch).
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = push_data_i;
                    end else begin
                        tail_d = push_data_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_d = push_data_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // NOTE: payload slots carry no reset; count alone decides which slots hold live data.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: issues sequential IMEM reads, queues responses,
// handles redirects. Optional bubble counter enabled by FETCH_BUBBLE_CNT_EN.
module pc_fetch_unit
    import mips31_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_ena,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    pc_fetch_unit_if.master  imem,
    output logic             if_valid,
    output logic [31:0]      if_pc_out,
    output logic [31:0]      if_instr_out
`ifdef FETCH_BUBBLE_CNT_EN
    ,
    output logic [31:0]      fetch_bubble_cnt
`endif
);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         inflight_q, inflight_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic [1:0]   count;
    logic [2:0]   occupancy;
    fetch_entry_t head;
    fetch_entry_t push_data;
    logic         pop;
    logic         issue;
    logic         push;

    assign pop       = if_ena & if_valid;
    assign occupancy = {1'b0, count} + {2'b00, inflight_q};
    // A slot freed by this cycle's pop may already be claimed by a new issue.
    assign issue     = !reset && !redirect_valid && (occupancy < (3'd2 + {2'b00, pop}));
    assign push      = inflight_q && !redirect_valid;
    assign push_data = '{pc: inflight_pc_q, instr: imem.imem_rdata};

    fetch_queue u_fetch_queue (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .count_o     (count),
        .head_o      (head)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (redirect_valid) begin
            fetch_pc_d = align_word(redirect_pc);
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + PC_INCR;
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign imem.imem_en   = issue;
    assign imem.imem_addr = fetch_pc_q;

    assign if_valid     = (count != 2'd0);
    assign if_pc_out    = if_valid ? head.pc    : 32'h0;
    assign if_instr_out = if_valid ? head.instr : INSTR_NOP;

`ifdef FETCH_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (if_ena && !if_valid && !redirect_valid) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_bubble_cnt = bubble_cnt_q;
`endif

endmodule
